// File: rtl/key_evt_pkg.sv
// Shared state encoding and default timing for the key event FSM.
// Defaults assume a 100 MHz clock.
package key_evt_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRESS1,
        ST_WAIT2,
        ST_PRESS2,
        ST_LONG
    } state_t;

    localparam int LONG_CYC_DEF    = 100_000_000;
    localparam int DBL_GAP_CYC_DEF = 30_000_000;
    localparam int REPEAT_CYC_DEF  = 20_000_000;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/key_edge_det.sv
// Arming, previous-level tracking and press/release edge strobes.
// Strobes are combinational; key_state is registered.
module key_edge_det #(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_in,
    output logic press_e,
    output logic release_e,
    output logic key_state
);

    logic pressed;
    logic key_prev;
    logic armed;

    assign pressed   = key_in ^ ACTIVE_LOW;
    assign press_e   = armed & pressed & ~key_prev;
    assign release_e = armed & ~pressed & key_prev;

    // A key held through reset stays unarmed until it is seen released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_prev  <= 1'b0;
            armed     <= 1'b0;
            key_state <= 1'b0;
        end else begin
            key_prev  <= pressed;
            key_state <= armed & pressed;
            if (!pressed) armed <= 1'b1;
        end
    end

endmodule

// File: rtl/key_event_fsm.sv
// Key gesture FSM: press/release, click, double click, long press
// and auto-repeat pulses, all registered and one cycle wide.
module key_event_fsm
    import key_evt_pkg::*;
#(
    parameter bit ACTIVE_LOW  = 1'b1,
    parameter int LONG_CYC    = LONG_CYC_DEF,
    parameter int DBL_GAP_CYC = DBL_GAP_CYC_DEF,
    parameter int REPEAT_CYC  = REPEAT_CYC_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_in,
    output logic key_state,
    output logic press_p,
    output logic release_p,
    output logic click_p,
    output logic dbl_p,
    output logic long_p,
    output logic rep_p
);

    localparam int CNT_MAX = max3(LONG_CYC, DBL_GAP_CYC, REPEAT_CYC);
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] LONG_T = CW'(LONG_CYC - 1);
    localparam logic [CW-1:0] GAP_T  = CW'(DBL_GAP_CYC - 1);
    localparam logic [CW-1:0] REP_T  = CW'(REPEAT_CYC - 1);
    localparam logic [CW-1:0] SAT    = CW'(CNT_MAX);

    logic press_e;
    logic release_e;

    key_edge_det #(
        .ACTIVE_LOW(ACTIVE_LOW)
    ) u_edge (
        .clk      (clk),
        .rst_n    (rst_n),
        .key_in   (key_in),
        .press_e  (press_e),
        .release_e(release_e),
        .key_state(key_state)
    );

    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nx;
    logic          clr;
    logic          click_nx;
    logic          dbl_nx;
    logic          long_nx;
    logic          rep_nx;

    always_comb begin
        state_nx = state;
        clr      = 1'b0;
        click_nx = 1'b0;
        dbl_nx   = 1'b0;
        long_nx  = 1'b0;
        rep_nx   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (press_e) state_nx = ST_PRESS1;
            end
            ST_PRESS1: begin
                if (release_e) begin
                    state_nx = ST_WAIT2;
                end else if (cnt == LONG_T) begin
                    long_nx  = 1'b1;
                    state_nx = ST_LONG;
                end
            end
            // A press on the terminal cycle still wins over the click.
            ST_WAIT2: begin
                if (press_e) begin
                    state_nx = ST_PRESS2;
                end else if (cnt == GAP_T) begin
                    click_nx = 1'b1;
                    state_nx = ST_IDLE;
                end
            end
            ST_PRESS2: begin
                if (release_e) begin
                    dbl_nx   = 1'b1;
                    state_nx = ST_IDLE;
                end else if (cnt == LONG_T) begin
                    long_nx  = 1'b1;
                    state_nx = ST_LONG;
                end
            end
            ST_LONG: begin
                if (release_e) begin
                    state_nx = ST_IDLE;
                end else if (cnt == REP_T) begin
                    rep_nx = 1'b1;
                    clr    = 1'b1;
                end
            end
            default: state_nx = ST_IDLE;
        endcase

        if (state_nx != state || clr) begin
            cnt_nx = '0;
        end else if (cnt != SAT) begin
            cnt_nx = cnt + CW'(1);
        end else begin
            cnt_nx = cnt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            press_p   <= 1'b0;
            release_p <= 1'b0;
            click_p   <= 1'b0;
            dbl_p     <= 1'b0;
            long_p    <= 1'b0;
            rep_p     <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            press_p   <= press_e;
            release_p <= release_e;
            click_p   <= click_nx;
            dbl_p     <= dbl_nx;
            long_p    <= long_nx;
            rep_p     <= rep_nx;
        end
    end

endmodule

// File: tb/tb_key_event_fsm.sv
// Bench for key_event_fsm: timestamp-based gesture model checked every
// cycle, plus directed scenarios with literal timing expectations.
module tb_key_event_fsm;

    localparam int LONG = 20;
    localparam int GAP  = 8;
    localparam int REP  = 5;

    logic clk    = 1'b0;
    logic rst_n  = 1'b1;
    logic key_in = 1'b1;

    logic key_state, press_p, release_p, click_p, dbl_p, long_p, rep_p;

    key_event_fsm #(
        .ACTIVE_LOW (1'b1),
        .LONG_CYC   (LONG),
        .DBL_GAP_CYC(GAP),
        .REPEAT_CYC (REP)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .key_in   (key_in),
        .key_state(key_state),
        .press_p  (press_p),
        .release_p(release_p),
        .click_p  (click_p),
        .dbl_p    (dbl_p),
        .long_p   (long_p),
        .rep_p    (rep_p)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Gesture model driven by timestamps of accepted edges.
    int t = 0;
    bit m_prev, m_armed, m_held, m_second, m_long, m_pending;
    int tp, tr, tl;
    bit e_state, e_press, e_rel, e_click, e_dbl, e_long, e_rep;

    always @(posedge clk or negedge rst_n) begin
        bit p, ep, er;
        if (!rst_n) begin
            m_prev = 0; m_armed = 0; m_held = 0; m_second = 0;
            m_long = 0; m_pending = 0;
            {e_state, e_press, e_rel, e_click, e_dbl, e_long, e_rep} = '0;
        end else begin
            t++;
            p  = ~key_in;
            ep = m_armed && p && !m_prev;
            er = m_armed && !p && m_prev;
            {e_click, e_dbl, e_long, e_rep} = '0;
            e_state = m_armed && p;
            e_press = ep;
            e_rel   = er;
            if (ep) begin
                m_held = 1; tp = t; m_long = 0;
                m_second = m_pending;
                m_pending = 0;
            end else if (er) begin
                m_held = 0;
                if (!m_long) begin
                    if (m_second) e_dbl = 1;
                    else begin m_pending = 1; tr = t; end
                end
            end else if (m_pending && t - tr == GAP) begin
                e_click = 1; m_pending = 0;
            end else if (m_held && !m_long && t - tp == LONG) begin
                e_long = 1; m_long = 1; tl = t;
            end else if (m_held && m_long && t - tl == REP) begin
                e_rep = 1; tl = t;
            end
            if (!p) m_armed = 1;
            m_prev = p;
        end
    end

    int cyc = 0;
    int n_press, n_rel, n_click, n_dbl, n_long, n_rep;
    int f_press, l_press, f_rel, l_rel, c_click, c_dbl, c_long, f_rep, l_rep;

    always @(posedge clk) begin
        #1;
        cyc++;
        chk("key_state", int'(key_state), int'(e_state));
        chk("press_p",   int'(press_p),   int'(e_press));
        chk("release_p", int'(release_p), int'(e_rel));
        chk("click_p",   int'(click_p),   int'(e_click));
        chk("dbl_p",     int'(dbl_p),     int'(e_dbl));
        chk("long_p",    int'(long_p),    int'(e_long));
        chk("rep_p",     int'(rep_p),     int'(e_rep));
        if (press_p) begin
            if (n_press == 0) f_press = cyc;
            l_press = cyc; n_press++;
        end
        if (release_p) begin
            if (n_rel == 0) f_rel = cyc;
            l_rel = cyc; n_rel++;
        end
        if (click_p) begin c_click = cyc; n_click++; end
        if (dbl_p)   begin c_dbl = cyc;   n_dbl++;   end
        if (long_p)  begin c_long = cyc;  n_long++;  end
        if (rep_p) begin
            if (n_rep == 0) f_rep = cyc;
            l_rep = cyc; n_rep++;
        end
    end

    task automatic clr_cnt();
        n_press = 0; n_rel = 0; n_click = 0;
        n_dbl = 0; n_long = 0; n_rep = 0;
    endtask

    task automatic hold(input logic lvl, input int n);
        key_in = lvl;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        clr_cnt();
        rst_n = 1'b0;
        #1;
        chk("reset_outs", int'({key_state, press_p, release_p, click_p,
                                dbl_p, long_p, rep_p}), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        hold(1, 4);

        // 1: single click
        clr_cnt();
        hold(0, 3);
        hold(1, 20);
        chk("t1_press_n", n_press, 1);
        chk("t1_rel_n",   n_rel, 1);
        chk("t1_hold",    l_rel - l_press, 3);
        chk("t1_click_n", n_click, 1);
        chk("t1_click_t", c_click - l_rel, 8);
        chk("t1_dbl_n",   n_dbl, 0);
        chk("t1_long_n",  n_long, 0);

        // 2: double click
        clr_cnt();
        hold(0, 3);
        hold(1, 4);
        hold(0, 3);
        hold(1, 20);
        chk("t2_press_n", n_press, 2);
        chk("t2_gap",     l_press - f_rel, 4);
        chk("t2_dbl_n",   n_dbl, 1);
        chk("t2_dbl_t",   c_dbl - l_rel, 0);
        chk("t2_click_n", n_click, 0);

        // 3: long press with repeats
        clr_cnt();
        hold(0, 32);
        hold(1, 20);
        chk("t3_long_n",  n_long, 1);
        chk("t3_long_t",  c_long - l_press, 20);
        chk("t3_rep_n",   n_rep, 2);
        chk("t3_rep1_t",  f_rep - c_long, 5);
        chk("t3_rep2_t",  l_rep - c_long, 10);
        chk("t3_rel_n",   n_rel, 1);
        chk("t3_click_n", n_click, 0);
        chk("t3_dbl_n",   n_dbl, 0);

        // 4: key held through reset
        key_in = 1'b0;
        rst_n  = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        clr_cnt();
        hold(0, 5);
        chk("t4_held_press", n_press, 0);
        chk("t4_held_state", int'(key_state), 0);
        hold(1, 3);
        chk("t4_arm_rel", n_rel, 0);
        hold(0, 3);
        chk("t4_press_n", n_press, 1);
        chk("t4_state",   int'(key_state), 1);
        hold(1, 20);

        // 5: second press exactly on the gap terminal cycle
        clr_cnt();
        hold(0, 3);
        hold(1, 8);
        hold(0, 3);
        hold(1, 20);
        chk("t5_gap",     l_press - f_rel, 8);
        chk("t5_click_n", n_click, 0);
        chk("t5_dbl_n",   n_dbl, 1);

        // 6: reset during the double-click gap
        clr_cnt();
        hold(0, 3);
        hold(1, 4);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_outs", int'({key_state, press_p, release_p, click_p,
                                 dbl_p, long_p, rep_p}), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        hold(1, 20);
        chk("t6_click_n", n_click, 0);
        chk("t6_dbl_n",   n_dbl, 0);
        chk("t6_rel_n",   n_rel, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
